// File: rtl/pcs_loopback_pkg.sv
// Shared types and constants for the PCS near-end loopback with elastic buffer.
package pcs_loopback_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [7:0] DEF_IDLE_BYTE = 8'h07;
   localparam int         IDLE_MAX_W    = 4096;

   // Idle byte replicated across the low `width` bits; callers cast to their width.
   function automatic logic [IDLE_MAX_W-1:0] idle_word(input int width, input logic [7:0] b);
      logic [IDLE_MAX_W-1:0] w;
      w = '0;
      for (int i = 0; i < IDLE_MAX_W / 8; i++) begin
         if (i * 8 < width) w[i*8 +: 8] = b;
      end
      return w;
   endfunction

endpackage

// File: rtl/pcs_loopback_fifo.sv
// Synchronous elastic FIFO with wrap-bit pointers, async reset and synchronous flush.
module pcs_loopback_fifo
   import pcs_loopback_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic                     i_wr,
   input  logic                     i_rd,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_lvl
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_wr) r_wptr <= r_wptr + 1'b1;
         if (i_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage carries no reset; only pointers define valid contents.
   always_ff @(posedge clk) begin
      if (i_wr && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign o_lvl   = r_wptr - r_rptr;
   assign o_full  = (o_lvl == DEPTH_L);
   assign o_empty = (r_wptr == r_rptr);
   assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/pcs_loopback_elastic.sv
// Multi-lane PCS near-end loopback: buffers locked RX words, replays them on TX once primed.
module pcs_loopback_elastic
   import pcs_loopback_pkg::*;
#(
   parameter int         LANE_N    = 1,
   parameter int         DATA_W    = 64,
   parameter int         DEPTH     = 8,
   parameter int         FILL_TH   = 4,
   parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       loop_en_i,
   input  logic                       clr_i,
   input  logic [LANE_N-1:0]          rx_locked_i,
   input  logic                       rx_valid_i,
   input  logic [LANE_N*DATA_W-1:0]   rx_par_data_i,
   input  logic                       tx_ready_i,
   output logic [LANE_N*DATA_W-1:0]   tx_par_data_o,
   output logic                       tx_loop_active_o,
   output logic [$clog2(DEPTH):0]     lvl_o,
   output logic                       ovf_o,
   output logic                       udf_o,
   output state_t                     dbg_state_o
);

   localparam int          W         = LANE_N * DATA_W;
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] FILL_LVL  = (AW+1)'(FILL_TH);
   localparam logic [W-1:0] IDLE_WORD = W'(idle_word(W, IDLE_BYTE));

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "DEPTH must be a power of 2 and at least 2");
   end
   if (FILL_TH < 1 || FILL_TH > DEPTH) begin : g_bad_fill
      $fatal(1, "FILL_TH must lie in 1..DEPTH");
   end
   if (DATA_W < 8 || (DATA_W % 8) != 0 || W > IDLE_MAX_W) begin : g_bad_width
      $fatal(1, "DATA_W must be a non-zero multiple of 8 within the idle pattern range");
   end

   state_t       r_state;
   state_t       w_state_nxt;
   logic         w_go;
   logic         w_wr;
   logic         w_wr_acc;
   logic         w_rd;
   logic         w_udf_ev;
   logic         w_ovf_ev;
   logic         w_full;
   logic         w_empty;
   logic [AW:0]  w_lvl;
   logic [W-1:0] w_head;

   // Handshake: a write is offered when rx_valid_i is high while enabled and locked;
   // a read is taken when tx_ready_i is high in RUN with data present. A read frees a
   // slot in the same cycle, so a write against a full buffer is accepted if a read coincides.
   assign w_go     = (&rx_locked_i) & loop_en_i;
   assign w_wr     = rx_valid_i & w_go & (r_state != ST_IDLE);
   assign w_rd     = tx_ready_i & w_go & (r_state == ST_RUN) & ~w_empty;
   assign w_udf_ev = tx_ready_i & w_go & (r_state == ST_RUN) & w_empty;
   assign w_wr_acc = w_wr & (~w_full | w_rd);
   assign w_ovf_ev = w_wr & w_full & ~w_rd;

   pcs_loopback_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (~w_go),
      .i_wr    (w_wr_acc),
      .i_rd    (w_rd),
      .i_data  (rx_par_data_i),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_lvl   (w_lvl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_go) w_state_nxt = ST_FILL;
         ST_FILL: begin
            if (!w_go)                 w_state_nxt = ST_IDLE;
            else if (w_lvl >= FILL_LVL) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!w_go)         w_state_nxt = ST_IDLE;
            else if (w_udf_ev) w_state_nxt = ST_FILL;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Losing go forces idle fill even without tx_ready_i so stale data never lingers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_par_data_o <= IDLE_WORD;
         ovf_o         <= 1'b0;
         udf_o         <= 1'b0;
      end else begin
         if (w_rd)                       tx_par_data_o <= w_head;
         else if (tx_ready_i || !w_go)   tx_par_data_o <= IDLE_WORD;
         if (w_ovf_ev)   ovf_o <= 1'b1;
         else if (clr_i) ovf_o <= 1'b0;
         if (w_udf_ev)   udf_o <= 1'b1;
         else if (clr_i) udf_o <= 1'b0;
      end
   end

   assign tx_loop_active_o = (r_state == ST_RUN);
   assign lvl_o            = w_lvl;
   assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_pcs_loopback_elastic.sv
// Randomized self-checking bench for pcs_loopback_elastic against a queue-based reference model.
module tb_pcs_loopback_elastic;
   import pcs_loopback_pkg::*;

   localparam int LANE_N  = 2;
   localparam int DATA_W  = 64;
   localparam int DEPTH   = 8;
   localparam int FILL_TH = 4;
   localparam int W       = LANE_N * DATA_W;
   localparam logic [W-1:0] IDLE_W = {16{8'h07}};

   logic            clk;
   logic            reset;
   logic            loop_en_i;
   logic            clr_i;
   logic [1:0]      rx_locked_i;
   logic            rx_valid_i;
   logic [W-1:0]    rx_par_data_i;
   logic            tx_ready_i;
   logic [W-1:0]    tx_par_data_o;
   logic            tx_loop_active_o;
   logic [3:0]      lvl_o;
   logic            ovf_o;
   logic            udf_o;
   state_t          dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: buffered words plus two abstract flags
   logic [W-1:0] exp_q[$];
   logic         m_enabled;
   logic         m_running;
   logic [W-1:0] m_tx;
   logic         m_ovf;
   logic         m_udf;

   pcs_loopback_elastic #(
      .LANE_N(LANE_N), .DATA_W(DATA_W), .DEPTH(DEPTH), .FILL_TH(FILL_TH), .IDLE_BYTE(8'h07)
   ) dut (
      .clk(clk), .reset(reset), .loop_en_i(loop_en_i), .clr_i(clr_i),
      .rx_locked_i(rx_locked_i), .rx_valid_i(rx_valid_i), .rx_par_data_i(rx_par_data_i),
      .tx_ready_i(tx_ready_i), .tx_par_data_o(tx_par_data_o),
      .tx_loop_active_o(tx_loop_active_o), .lvl_o(lvl_o), .ovf_o(ovf_o), .udf_o(udf_o),
      .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_enabled = 1'b0;
      m_running = 1'b0;
      m_tx      = IDLE_W;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic go;
      logic ovf_ev;
      logic udf_ev;
      int   sz0;
      go     = (rx_locked_i == 2'b11) && loop_en_i;
      ovf_ev = 1'b0;
      udf_ev = 1'b0;
      if (!go) begin
         exp_q.delete();
         m_enabled = 1'b0;
         m_running = 1'b0;
         m_tx      = IDLE_W;
      end else if (!m_enabled) begin
         m_enabled = 1'b1;
         if (tx_ready_i) m_tx = IDLE_W;
      end else begin
         sz0 = exp_q.size();
         if (m_running && tx_ready_i) begin
            if (sz0 > 0) m_tx = exp_q.pop_front();
            else begin
               m_tx   = IDLE_W;
               udf_ev = 1'b1;
            end
         end else if (tx_ready_i) begin
            m_tx = IDLE_W;
         end
         if (rx_valid_i) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rx_par_data_i);
            else                      ovf_ev = 1'b1;
         end
         if (udf_ev)                            m_running = 1'b0;
         else if (!m_running && sz0 >= FILL_TH) m_running = 1'b1;
      end
      if (ovf_ev)     m_ovf = 1'b1;
      else if (clr_i) m_ovf = 1'b0;
      if (udf_ev)     m_udf = 1'b1;
      else if (clr_i) m_udf = 1'b0;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string phase);
      check({phase, ":tx"},     tx_par_data_o,             m_tx);
      check({phase, ":active"}, W'(tx_loop_active_o),      W'(m_running));
      check({phase, ":lvl"},    W'(lvl_o),                 W'(exp_q.size()));
      check({phase, ":ovf"},    W'(ovf_o),                 W'(m_ovf));
      check({phase, ":udf"},    W'(udf_o),                 W'(m_udf));
   endtask

   // driver: one clock edge, then compare away from the edge
   task automatic tick(input string phase);
      model_step();
      @(posedge clk);
      #1;
      check_all(phase);
      if (rx_valid_i) rx_par_data_i = rand_word();
   endtask

   initial begin
      reset         = 1'b1;
      loop_en_i     = 1'b0;
      clr_i         = 1'b0;
      rx_locked_i   = 2'b00;
      rx_valid_i    = 1'b0;
      rx_par_data_i = '0;
      tx_ready_i    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_all("reset");
      tick("reset_hold");

      // prime and run
      rx_locked_i   = 2'b11;
      loop_en_i     = 1'b1;
      tx_ready_i    = 1'b1;
      rx_valid_i    = 1'b1;
      rx_par_data_i = rand_word();
      for (int i = 0; i < 20; i++) tick("prime_run");

      // overflow: stall TX while writing
      tx_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) tick("overflow");
      clr_i = 1'b1;
      tick("ovf_clr");
      clr_i = 1'b0;

      // underflow: drain, then resume and clear
      tx_ready_i = 1'b1;
      rx_valid_i = 1'b0;
      for (int i = 0; i < 12; i++) tick("underflow");
      rx_valid_i    = 1'b1;
      rx_par_data_i = rand_word();
      for (int i = 0; i < 8; i++) tick("reprime");
      clr_i = 1'b1;
      tick("udf_clr");
      clr_i = 1'b0;

      // lock loss on lane 1 mid-RUN, then relock
      rx_locked_i = 2'b01;
      tick("lock_loss");
      rx_locked_i = 2'b11;
      for (int i = 0; i < 10; i++) tick("relock");

      // randomized traffic with occasional lock/enable drops and clears
      for (int i = 0; i < 400; i++) begin
         loop_en_i     = ($urandom_range(0, 49) != 0);
         rx_locked_i   = ($urandom_range(0, 59) == 0) ? 2'b10 : 2'b11;
         rx_valid_i    = ($urandom_range(0, 3) != 0);
         tx_ready_i    = ($urandom_range(0, 3) != 0);
         clr_i         = ($urandom_range(0, 15) == 0);
         rx_par_data_i = rand_word();
         tick("random");
      end

      // async reset between edges while running
      loop_en_i   = 1'b1;
      rx_locked_i = 2'b11;
      rx_valid_i  = 1'b1;
      tx_ready_i  = 1'b1;
      clr_i       = 1'b0;
      for (int i = 0; i < 8; i++) tick("pre_async");
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) tick("post_async");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
